// File: rtl/i2c_arbiter_pkg.sv
// Shared types and constants for the board I2C bus arbiter.
// Holds the arbiter state encoding, the bus bundle type and the revoke counter helper.
package i2c_arbiter_pkg;

  localparam int MAX_CLIENTS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } ARB_STATE;

  typedef struct packed {
    logic [MAX_CLIENTS-1:0] Request;
    logic [MAX_CLIENTS-1:0] Grant;
    logic [MAX_CLIENTS-1:0] SClk;
    logic [MAX_CLIENTS-1:0] Data;
  } I2C_BUS;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_bus_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after the pointer,
// wrapping N-1 -> 0; returns one-hot winner, its index and a valid flag.
module rr_pick #(
  parameter int N = 2
) (
  input  logic [N-1:0]         request_i,
  input  logic [$clog2(N)-1:0] pointer_i,
  output logic [N-1:0]         winner_o,
  output logic [$clog2(N)-1:0] index_o,
  output logic                 valid_o
);

  localparam int PW = $clog2(N);

  always_comb begin
    int   idx;
    logic found;
    winner_o = '0;
    index_o  = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(pointer_i) + k) % N;
      if (!found && request_i[idx]) begin
        winner_o[idx] = 1'b1;
        index_o       = PW'(idx);
        found         = 1'b1;
      end else begin
        found = found;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin owner arbiter and pin mux for the shared board I2C bus, with bus-free gap.
// Define I2C_ARB_WATCHDOG_EN to enable the stuck-owner watchdog (revoke after TIMEOUT cycles).
module i2c_bus_arbiter
  import i2c_arbiter_pkg::*;
#(
  parameter int N          = 2,
  parameter int GAP_CYCLES = 8,
  parameter int TIMEOUT    = 2**20
) (
  input  logic         ipClk,
  input  logic         ipReset,
  input  logic [N-1:0] ipRequest,
  output logic [N-1:0] opGrant,
  input  logic [N-1:0] ipClientSClk,
  input  logic [N-1:0] ipClientData,
  output logic         opI2C_SClk,
  output logic         opI2C_Data,
  output logic         opBusy,
  output logic         opTimeout,
  output logic [7:0]   opTimeoutCount
);

  localparam int PW = $clog2(N);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  ARB_STATE        state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            sclk_q, sclk_d;
  logic            data_q, data_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic [N-1:0]    eligible_s;
  logic [N-1:0]    pick_winner_s;
  logic [PW-1:0]   pick_index_s;
  logic            pick_valid_s;

`ifdef I2C_ARB_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT);
  logic [WW-1:0]   wd_q, wd_d;
  logic [N-1:0]    blocked_q, blocked_d;
  logic            timeout_q, timeout_d;
  logic [7:0]      count_q, count_d;

  // A revoked client stays out of arbitration until it lets go of its request.
  assign eligible_s = ipRequest & ~blocked_q;
`else
  assign eligible_s = ipRequest;
`endif

  rr_pick #(.N(N)) u_pick (
    .request_i (eligible_s),
    .pointer_i (ptr_q),
    .winner_o  (pick_winner_s),
    .index_o   (pick_index_s),
    .valid_o   (pick_valid_s)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    grant_d = grant_q;
    gap_d   = gap_q;
    sclk_d  = 1'b0;
    data_d  = 1'b0;
`ifdef I2C_ARB_WATCHDOG_EN
    wd_d      = wd_q;
    blocked_d = blocked_q & ipRequest;
    timeout_d = 1'b0;
    count_d   = count_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid_s) begin
          state_d = GRANT;
          grant_d = pick_winner_s;
          owner_d = pick_index_s;
          ptr_d   = (pick_index_s == PW'(N - 1)) ? '0 : pick_index_s + PW'(1);
`ifdef I2C_ARB_WATCHDOG_EN
          wd_d    = '0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      GRANT: begin
        if (!ipRequest[owner_q]) begin
          state_d = GAP;
          grant_d = '0;
          gap_d   = '0;
`ifdef I2C_ARB_WATCHDOG_EN
        end else if (wd_q == WW'(TIMEOUT - 1)) begin
          state_d            = GAP;
          grant_d            = '0;
          gap_d              = '0;
          timeout_d          = 1'b1;
          count_d            = sat_inc8(count_q);
          blocked_d[owner_q] = 1'b1;
`endif
        end else begin
          sclk_d = ipClientSClk[owner_q];
          data_d = ipClientData[owner_q];
`ifdef I2C_ARB_WATCHDOG_EN
          wd_d   = wd_q + WW'(1);
`endif
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      gap_q   <= '0;
      sclk_q  <= 1'b0;
      data_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      gap_q   <= gap_d;
      sclk_q  <= sclk_d;
      data_q  <= data_d;
    end
  end

`ifdef I2C_ARB_WATCHDOG_EN
  always_ff @(posedge ipClk) begin
    if (ipReset) begin
      wd_q      <= '0;
      blocked_q <= '0;
      timeout_q <= 1'b0;
      count_q   <= 8'd0;
    end else begin
      wd_q      <= wd_d;
      blocked_q <= blocked_d;
      timeout_q <= timeout_d;
      count_q   <= count_d;
    end
  end

  assign opTimeout      = timeout_q;
  assign opTimeoutCount = count_q;
`else
  assign opTimeout      = 1'b0;
  assign opTimeoutCount = 8'd0;
`endif

  assign opGrant    = grant_q;
  assign opI2C_SClk = sclk_q;
  assign opI2C_Data = data_q;
  assign opBusy     = (state_q != IDLE);

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Directed self-checking bench for i2c_bus_arbiter (N=3, GAP_CYCLES=8, TIMEOUT=64).
module tb_i2c_bus_arbiter;

  localparam int N   = 3;
  localparam int GAP = 8;
  localparam int TO  = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, grant, csclk, cdata;
  logic         psclk, pdata, busy, tmo;
  logic [7:0]   tcount;

  int checks = 0;
  int passes = 0;
  int n;
  int pulses;
  int first_drop;
  logic [N-1:0] g;

  i2c_bus_arbiter #(.N(N), .GAP_CYCLES(GAP), .TIMEOUT(TO)) dut (
    .ipClk          (clk),
    .ipReset        (rst),
    .ipRequest      (req),
    .opGrant        (grant),
    .ipClientSClk   (csclk),
    .ipClientData   (cdata),
    .opI2C_SClk     (psclk),
    .opI2C_Data     (pdata),
    .opBusy         (busy),
    .opTimeout      (tmo),
    .opTimeoutCount (tcount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance until a grant appears or the budget runs out; returns cycles taken and grant.
  task automatic wait_grant(output int cycles, output logic [N-1:0] gnt);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (grant == '0 && cycles < 30);
    gnt = grant;
  endtask

  initial begin
    rst = 1'b1; req = '0; csclk = '0; cdata = '0;
    tick(); tick();
    check("reset_grant", grant, 0);
    check("reset_sclk", psclk, 0);
    check("reset_data", pdata, 0);
    check("reset_busy", busy, 0);
    check("reset_timeout", tmo, 0);
    check("reset_count", tcount, 0);

    rst = 1'b0;
    tick();
    check("idle_no_grant", grant, 0);

    // Single client: one-cycle grant latency, release, gap timing
    req = 3'b001; tick();
    check("single_grant", grant, 3'b001);
    check("single_busy", busy, 1);
    repeat (19) tick();
    check("single_hold", grant, 3'b001);
    req = 3'b000; tick();
    check("drop_clears", grant, 0);
    check("gap_busy", busy, 1);
    req = 3'b001;
    wait_grant(n, g);
    check("gap_latency", n, GAP + 1);
    check("gap_regrant", g, 3'b001);
    req = 3'b000; tick();
    repeat (GAP) tick();
    check("back_idle", busy, 0);

    // Pointer now 1: client 1 wins; pin mux ignores client 0
    req = 3'b011; tick();
    check("rr_after_0", grant, 3'b010);
    cdata = 3'b010; csclk = 3'b001; tick();
    check("mux_data_owner", pdata, 1);
    check("mux_sclk_ungranted", psclk, 0);
    csclk = 3'b011; tick();
    check("mux_sclk_owner", psclk, 1);
    csclk = 3'b001; cdata = 3'b001; tick();
    check("mux_data_ignored", pdata, 0);
    check("mux_sclk_ignored", psclk, 0);
    req = 3'b001; cdata = '0; csclk = '0; tick();
    check("mux_drop_grant", grant, 0);
    check("mux_drop_pins", pdata, 0);
    wait_grant(n, g);
    check("waiter_latency", n, GAP + 1);
    check("waiter_grant", g, 3'b001);

    // Reset mid-grant
    cdata = 3'b001; tick();
    check("pre_reset_data", pdata, 1);
    rst = 1'b1; tick();
    check("midreset_grant", grant, 0);
    check("midreset_data", pdata, 0);
    check("midreset_busy", busy, 0);

    // All requesting from reset: 0,1,2,0 with pointer restarted
    req = 3'b111; cdata = '0; rst = 1'b0; tick();
    check("rr_first", grant, 3'b001);
    req = 3'b110; tick(); req = 3'b111;
    wait_grant(n, g);
    check("rr_second", g, 3'b010);
    req = 3'b101; tick(); req = 3'b111;
    wait_grant(n, g);
    check("rr_third", g, 3'b100);
    req = 3'b011; tick(); req = 3'b111;
    wait_grant(n, g);
    check("rr_fourth", g, 3'b001);

    // Client 0 holds for 100 cycles with client 1 waiting
    req = 3'b011; pulses = 0; first_drop = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (tmo) pulses++;
      if (grant != 3'b001 && first_drop == 0) first_drop = i;
      if (!$onehot0(grant)) check("onehot_hold", grant, 0);
    end
`ifdef I2C_ARB_WATCHDOG_EN
    check("wd_revoke_cycle", first_drop, TO);
    check("wd_pulses", pulses, 1);
    check("wd_count", tcount, 1);
    check("wd_next_owner", grant, 3'b010);
    req = 3'b001; tick();
    repeat (GAP + 6) tick();
    check("wd_blocked", grant, 0);
    req = 3'b000; tick();
    req = 3'b001;
    wait_grant(n, g);
    check("wd_unblocked", g, 3'b001);
`else
    check("hold_no_drop", first_drop, 0);
    check("hold_no_pulse", pulses, 0);
    check("hold_count", tcount, 0);
    check("hold_grant", grant, 3'b001);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
